// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Retires ALU results and formatted loads onto the register-file
//            write port; flags misaligned/timed-out loads, counts retirements.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mw_valid,
    output logic             mw_ready,
    input  logic [4:0]       mw_rd,
    input  logic [31:0]      mw_result,
    input  logic             mw_is_load,
    input  logic [1:0]       mw_load_size,
    input  logic             mw_load_signed,
    input  logic [1:0]       mw_addr_lo,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             write,
    output logic [4:0]       writeregsel,
    output logic [31:0]      writedata,
    output logic             err_misalign,
    output logic             err_timeout,
    output logic             stray_rsp,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] C_TLIMIT = TW'(TIMEOUT - 1);

    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_tcnt, w_tcnt_nx;
    logic [4:0]    r_rd;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [1:0]    r_addr;

    logic          w_accept, w_capture, w_retire;
    logic          w_write_nx, w_errm_nx, w_errt_nx, w_stray_nx;
    logic [4:0]    w_sel_nx;
    logic [31:0]   w_data_nx;
    logic          w_misalign;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_fmt;

    assign mw_ready = (r_state == ST_IDLE);
    assign w_accept = mw_valid & mw_ready;

    // Load alignment check and lane extraction from the captured load attributes
    always_comb begin
        w_misalign = 1'b0;
        w_byte     = mem_rdata[7:0];
        w_half     = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_fmt      = mem_rdata;
        case (r_addr)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_size)
            2'b00: w_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01: begin
                w_misalign = r_addr[0];
                w_fmt      = {{16{r_signed & w_half[15]}}, w_half};
            end
            2'b10: w_misalign = (r_addr != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_tcnt_nx  = r_tcnt;
        w_capture  = 1'b0;
        w_retire   = 1'b0;
        w_write_nx = 1'b0;
        w_sel_nx   = writeregsel;
        w_data_nx  = writedata;
        w_errm_nx  = 1'b0;
        w_errt_nx  = 1'b0;
        w_stray_nx = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stray_nx = mem_rvalid;
                if (w_accept) begin
                    if (mw_is_load) begin
                        w_capture  = 1'b1;
                        w_tcnt_nx  = '0;
                        w_state_nx = ST_WAIT_MEM;
                    end else begin
                        w_retire = 1'b1;
                        if (mw_rd != 5'd0) begin
                            w_write_nx = 1'b1;
                            w_sel_nx   = mw_rd;
                            w_data_nx  = mw_result;
                        end
                    end
                end
            end
            default: begin
                // A response arriving on the limit cycle still completes normally
                if (mem_rvalid) begin
                    w_state_nx = ST_IDLE;
                    w_retire   = 1'b1;
                    if (w_misalign) begin
                        w_errm_nx = 1'b1;
                    end else if (r_rd != 5'd0) begin
                        w_write_nx = 1'b1;
                        w_sel_nx   = r_rd;
                        w_data_nx  = w_fmt;
                    end
                end else if (r_tcnt == C_TLIMIT) begin
                    w_errt_nx  = 1'b1;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tcnt_nx = r_tcnt + TW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            r_rd         <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_addr       <= '0;
            write        <= 1'b0;
            writeregsel  <= '0;
            writedata    <= '0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            stray_rsp    <= 1'b0;
            instret      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_tcnt       <= w_tcnt_nx;
            write        <= w_write_nx;
            writeregsel  <= w_sel_nx;
            writedata    <= w_data_nx;
            err_misalign <= w_errm_nx;
            err_timeout  <= w_errt_nx;
            stray_rsp    <= w_stray_nx;
            if (w_capture) begin
                r_rd     <= mw_rd;
                r_size   <= mw_load_size;
                r_signed <= mw_load_signed;
                r_addr   <= mw_addr_lo;
            end
            if (w_retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Directed and randomized self-checking bench for writeback_stage.
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             mw_valid;
    logic             mw_ready;
    logic [4:0]       mw_rd;
    logic [31:0]      mw_result;
    logic             mw_is_load;
    logic [1:0]       mw_load_size;
    logic             mw_load_signed;
    logic [1:0]       mw_addr_lo;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             write;
    logic [4:0]       writeregsel;
    logic [31:0]      writedata;
    logic             err_misalign;
    logic             err_timeout;
    logic             stray_rsp;
    logic [CNT_W-1:0] instret;

    int passed = 0;
    int total  = 0;
    logic [CNT_W-1:0] exp_instret;

    writeback_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_rd(mw_rd),
        .mw_result(mw_result), .mw_is_load(mw_is_load),
        .mw_load_size(mw_load_size), .mw_load_signed(mw_load_signed),
        .mw_addr_lo(mw_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .err_misalign(err_misalign), .err_timeout(err_timeout),
        .stray_rsp(stray_rsp), .instret(instret)
    );

    always #5 clk = ~clk;

    // Reference load formatting: {ok, value} from plain shift/mask arithmetic
    function automatic logic [32:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] addr, input logic [31:0] rdata);
        logic [31:0] v;
        logic        ok;
        case (size)
            2'd0: begin
                ok = 1'b1;
                v  = (rdata >> (8 * addr)) & 32'hFF;
                if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                ok = (addr % 2 == 0);
                v  = (rdata >> (8 * addr)) & 32'hFFFF;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            2'd2: begin
                ok = (addr == 2'd0);
                v  = rdata;
            end
            default: begin
                ok = 1'b0;
                v  = 32'd0;
            end
        endcase
        return {ok, v};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [1:0] size,
                              input logic sgn, input logic [1:0] addr);
        mw_valid = 1'b1; mw_is_load = 1'b1; mw_rd = rd;
        mw_load_size = size; mw_load_signed = sgn; mw_addr_lo = addr;
        cycle();
        mw_valid = 1'b0; mw_is_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(); cycle();
        total++; if (write !== 1'b0) $display("FAIL reset_write: got %b expected 0", write); else passed++;
        total++; if (writeregsel !== 5'd0 || writedata !== 32'd0)
            $display("FAIL reset_sel_data: got %0d/%h expected 0/0", writeregsel, writedata); else passed++;
        total++; if ({err_misalign, err_timeout, stray_rsp} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {err_misalign, err_timeout, stray_rsp}); else passed++;
        total++; if (instret !== '0) $display("FAIL reset_instret: got %0d expected 0", instret); else passed++;
        total++; if (mw_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", mw_ready); else passed++;
        rst = 1'b0;
        exp_instret = '0;
    endtask

    task automatic test_alu_stream();
        logic [4:0]  rds [3] = '{5'd3, 5'd5, 5'd7};
        logic [31:0] res [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 3; i++) begin
            mw_valid = 1'b1; mw_is_load = 1'b0; mw_rd = rds[i]; mw_result = res[i];
            total++; if (mw_ready !== 1'b1) $display("FAIL alu_ready[%0d]: got %b expected 1", i, mw_ready); else passed++;
            cycle();
            total++; if (write !== 1'b1 || writeregsel !== rds[i] || writedata !== res[i])
                $display("FAIL alu_write[%0d]: got %b/%0d/%h expected 1/%0d/%h", i, write, writeregsel, writedata, rds[i], res[i]);
            else passed++;
        end
        mw_valid = 1'b0;
        exp_instret = exp_instret + 3;
        total++; if (instret !== exp_instret) $display("FAIL alu_instret: got %0d expected %0d", instret, exp_instret); else passed++;
        cycle();
        total++; if (write !== 1'b0) $display("FAIL alu_pulse: got %b expected 0", write); else passed++;
    endtask

    task automatic test_load_byte();
        rst = 1'b1; cycle(); rst = 1'b0;
        exp_instret = '0;
        drive_load(5'd9, 2'b00, 1'b1, 2'd2);
        for (int k = 1; k <= 4; k++) begin
            total++; if (mw_ready !== 1'b0 || write !== 1'b0)
                $display("FAIL lb_wait[%0d]: got ready=%b write=%b expected 0/0", k, mw_ready, write); else passed++;
            if (k == 4) begin
                mem_rvalid = 1'b1; mem_rdata = 32'h1280_3456;
            end
            cycle();
        end
        mem_rvalid = 1'b0;
        exp_instret = exp_instret + 1;
        total++; if (write !== 1'b1 || writeregsel !== 5'd9 || writedata !== 32'hFFFF_FF80)
            $display("FAIL lb_write: got %b/%0d/%h expected 1/9/ffffff80", write, writeregsel, writedata); else passed++;
        total++; if (instret !== exp_instret) $display("FAIL lb_instret: got %0d expected %0d", instret, exp_instret); else passed++;
        total++; if (mw_ready !== 1'b1) $display("FAIL lb_ready: got %b expected 1", mw_ready); else passed++;
    endtask

    task automatic test_load_half();
        drive_load(5'd4, 2'b01, 1'b0, 2'd2);
        mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000;
        cycle();
        mem_rvalid = 1'b0;
        exp_instret = exp_instret + 1;
        total++; if (write !== 1'b1 || writedata !== 32'h0000_8001)
            $display("FAIL lh_write: got %b/%h expected 1/00008001", write, writedata); else passed++;
        drive_load(5'd6, 2'b01, 1'b1, 2'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        cycle();
        mem_rvalid = 1'b0;
        exp_instret = exp_instret + 1;
        total++; if (err_misalign !== 1'b1 || write !== 1'b0)
            $display("FAIL lh_misalign: got err=%b write=%b expected 1/0", err_misalign, write); else passed++;
        total++; if (writeregsel !== 5'd4 || writedata !== 32'h0000_8001)
            $display("FAIL lh_hold: got %0d/%h expected 4/00008001", writeregsel, writedata); else passed++;
        total++; if (instret !== exp_instret) $display("FAIL lh_instret: got %0d expected %0d", instret, exp_instret); else passed++;
        cycle();
        total++; if (err_misalign !== 1'b0) $display("FAIL lh_err_pulse: got %b expected 0", err_misalign); else passed++;
    endtask

    task automatic test_timeout();
        drive_load(5'd8, 2'b10, 1'b0, 2'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            cycle();
            total++; if (err_timeout !== (k == TIMEOUT) || write !== 1'b0)
                $display("FAIL to_cycle[%0d]: got err=%b write=%b expected %b/0", k, err_timeout, write, k == TIMEOUT);
            else passed++;
        end
        total++; if (mw_ready !== 1'b1 || instret !== exp_instret)
            $display("FAIL to_after: got ready=%b instret=%0d expected 1/%0d", mw_ready, instret, exp_instret); else passed++;
        drive_load(5'd8, 2'b10, 1'b0, 2'd0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k == TIMEOUT) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
            end
            cycle();
        end
        mem_rvalid = 1'b0;
        exp_instret = exp_instret + 1;
        total++; if (write !== 1'b1 || writedata !== 32'hCAFE_F00D || err_timeout !== 1'b0)
            $display("FAIL to_late_rsp: got %b/%h err=%b expected 1/cafef00d/0", write, writedata, err_timeout); else passed++;
    endtask

    task automatic test_rd_zero_stray();
        mw_valid = 1'b1; mw_is_load = 1'b0; mw_rd = 5'd0; mw_result = 32'hDEAD;
        cycle();
        mw_valid = 1'b0;
        exp_instret = exp_instret + 1;
        total++; if (write !== 1'b0 || instret !== exp_instret)
            $display("FAIL rd0: got write=%b instret=%0d expected 0/%0d", write, instret, exp_instret); else passed++;
        mem_rvalid = 1'b1;
        cycle();
        mem_rvalid = 1'b0;
        total++; if (stray_rsp !== 1'b1 || write !== 1'b0)
            $display("FAIL stray: got stray=%b write=%b expected 1/0", stray_rsp, write); else passed++;
        cycle();
        total++; if (stray_rsp !== 1'b0) $display("FAIL stray_pulse: got %b expected 0", stray_rsp); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        drive_load(5'd11, 2'b10, 1'b0, 2'd0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_instret = '0;
        total++; if (mw_ready !== 1'b1 || instret !== '0 || write !== 1'b0)
            $display("FAIL rstw_state: got ready=%b instret=%0d write=%b expected 1/0/0", mw_ready, instret, write); else passed++;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        cycle();
        mem_rvalid = 1'b0;
        total++; if (stray_rsp !== 1'b1 || write !== 1'b0 || instret !== '0 || err_timeout !== 1'b0)
            $display("FAIL rstw_rsp: got stray=%b write=%b instret=%0d errt=%b expected 1/0/0/0",
                     stray_rsp, write, instret, err_timeout); else passed++;
    endtask

    task automatic test_random();
        logic [4:0]  exp_sel = 5'd0;
        logic [31:0] exp_data = 32'd0;
        logic        exp_w, exp_em, exp_et, exp_st;
        logic [32:0] m;
        for (int n = 0; n < 80; n++) begin
            logic [4:0]  rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            logic        st_in = ($urandom_range(0, 3) == 0);
            exp_em = 1'b0; exp_et = 1'b0; exp_w = 1'b0; exp_st = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                logic [31:0] res = $urandom;
                mw_valid = 1'b1; mw_is_load = 1'b0; mw_rd = rd; mw_result = res;
                mem_rvalid = st_in;
                cycle();
                mem_rvalid = 1'b0;
                exp_instret = exp_instret + 1;
                exp_st = st_in;
                if (rd != 5'd0) begin
                    exp_w = 1'b1; exp_sel = rd; exp_data = res;
                end
            end else begin
                logic [1:0]  size = 2'($urandom_range(0, 3));
                logic        sgn  = 1'($urandom_range(0, 1));
                logic [1:0]  addr = 2'($urandom_range(0, 3));
                int          w    = $urandom_range(1, TIMEOUT + 2);
                logic [31:0] rdata = $urandom;
                mem_rvalid = st_in;
                drive_load(rd, size, sgn, addr);
                mem_rvalid = 1'b0;
                total++; if (write !== 1'b0 || stray_rsp !== st_in)
                    $display("FAIL rnd_accept[%0d]: got write=%b stray=%b expected 0/%b", n, write, stray_rsp, st_in); else passed++;
                for (int k = 1; k <= ((w <= TIMEOUT) ? w : TIMEOUT); k++) begin
                    mw_valid = 1'($urandom_range(0, 1)); mw_rd = 5'd1; mw_result = $urandom;
                    if (k == w) begin
                        mem_rvalid = 1'b1; mem_rdata = rdata;
                    end
                    cycle();
                end
                mem_rvalid = 1'b0; mw_valid = 1'b0;
                if (w <= TIMEOUT) begin
                    m = model_load(size, sgn, addr, rdata);
                    exp_instret = exp_instret + 1;
                    if (!m[32]) exp_em = 1'b1;
                    else if (rd != 5'd0) begin
                        exp_w = 1'b1; exp_sel = rd; exp_data = m[31:0];
                    end
                end else begin
                    exp_et = 1'b1;
                end
            end
            total++; if (write !== exp_w || writeregsel !== exp_sel || writedata !== exp_data)
                $display("FAIL rnd_wr[%0d]: got %b/%0d/%h expected %b/%0d/%h",
                         n, write, writeregsel, writedata, exp_w, exp_sel, exp_data); else passed++;
            total++; if (err_misalign !== exp_em || err_timeout !== exp_et || stray_rsp !== exp_st)
                $display("FAIL rnd_flags[%0d]: got %b%b%b expected %b%b%b",
                         n, err_misalign, err_timeout, stray_rsp, exp_em, exp_et, exp_st); else passed++;
            total++; if (instret !== exp_instret)
                $display("FAIL rnd_instret[%0d]: got %0d expected %0d", n, instret, exp_instret); else passed++;
        end
        mw_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mw_valid = 1'b0; mw_rd = '0; mw_result = '0; mw_is_load = 1'b0;
        mw_load_size = '0; mw_load_signed = 1'b0; mw_addr_lo = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        exp_instret = '0;
        test_reset();
        test_alu_stream();
        test_load_byte();
        test_load_half();
        test_timeout();
        test_rd_zero_stray();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
